// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern transmitter and its LFSR.
// The receive-side counter reuses the LFSR constants defined here.
package pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_SEND_WORD = 2'd2,
      ST_SEND_PAT  = 2'd3
   } state_t;

   localparam logic [11:0] PATTERN_DEFAULT = 12'h2F8;
   localparam logic [15:0] SEED_DEFAULT    = 16'hACE1;

   // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: fb = l[0]^l[2]^l[3]^l[5]
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam logic [3:0] WORD_MSB = 4'd15;
   localparam logic [3:0] PAT_MSB  = 4'd11;

   // An all-zero seed would lock the LFSR up.
   function automatic logic [15:0] fix_seed(input logic [15:0] s);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reset/load and a step enable.
// Reset and load both place the seed in the register.
module lfsr16
   import pattern_tx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;
   logic        fb;

   assign fb = ^(value_q & LFSR_TAPS);

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = seed;
      end else if (step) begin
         value_d = {fb, value_q[15:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= seed;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/pattern_tx.sv
// Serial PRBS word transmitter with on-request insertion of a fixed sync pattern.
//
//   state        | meaning
//   ST_IDLE      | not streaming, bit_valid low
//   ST_LOAD      | one cycle: seed the LFSR, point index at word MSB
//   ST_SEND_WORD | shifting out lfsr[index], MSB first
//   ST_SEND_PAT  | shifting out PATTERN[index], MSB first
module pattern_tx
   import pattern_tx_pkg::*;
#(
   parameter logic [15:0] SEED    = SEED_DEFAULT,
   parameter logic [11:0] PATTERN = PATTERN_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        inject,
   input  logic        bit_ready,
   output logic        bit_out,
   output logic        bit_valid,
   output logic        pat_active,
   output logic        busy,
   output logic [15:0] inj_count
);

   localparam logic [15:0] SEED_EFF = fix_seed(SEED);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        inj_pend_q, inj_pend_d;
   logic        stop_pend_q, stop_pend_d;
   logic [15:0] inj_count_q, inj_count_d;
   logic        lfsr_load, lfsr_step;
   logic [15:0] lfsr_val;
   logic        accept;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .seed  (SEED_EFF),
      .step  (lfsr_step),
      .value (lfsr_val)
   );

   // Outputs decode from registered state only; bit_ready never reaches them.
   always_comb begin
      bit_out    = 1'b0;
      bit_valid  = 1'b0;
      pat_active = 1'b0;
      case (state_q)
         ST_SEND_WORD: begin
            bit_out   = lfsr_val[idx_q];
            bit_valid = 1'b1;
         end
         ST_SEND_PAT: begin
            bit_out    = PATTERN[idx_q];
            bit_valid  = 1'b1;
            pat_active = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign accept    = bit_valid & bit_ready;
   assign inj_count = inj_count_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      inj_pend_d  = inj_pend_q  | (busy & inject);
      stop_pend_d = stop_pend_q | (busy & stop);
      inj_count_d = inj_count_q;
      lfsr_load   = 1'b0;
      lfsr_step   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            lfsr_load = 1'b1;
            idx_d     = WORD_MSB;
            state_d   = ST_SEND_WORD;
         end
         ST_SEND_WORD: begin
            if (accept) begin
               if (idx_q == 4'd0) begin
                  lfsr_step = 1'b1;
                  idx_d     = WORD_MSB;
                  if (inj_pend_q) begin
                     state_d    = ST_SEND_PAT;
                     idx_d      = PAT_MSB;
                     inj_pend_d = 1'b0;
                  end else if (stop_pend_q) begin
                     state_d     = ST_IDLE;
                     stop_pend_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q - 4'd1;
               end
            end
         end
         ST_SEND_PAT: begin
            if (accept) begin
               if (idx_q == 4'd0) begin
                  if (inj_count_q != 16'hFFFF) inj_count_d = inj_count_q + 16'd1;
                  idx_d   = WORD_MSB;
                  state_d = ST_SEND_WORD;
                  if (stop_pend_q) begin
                     // An inject that arrived during this pattern must not leak into the next start.
                     state_d     = ST_IDLE;
                     stop_pend_d = 1'b0;
                     inj_pend_d  = 1'b0;
                  end
               end else begin
                  idx_d = idx_q - 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= WORD_MSB;
         inj_pend_q  <= 1'b0;
         stop_pend_q <= 1'b0;
         inj_count_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         inj_pend_q  <= inj_pend_d;
         stop_pend_q <= stop_pend_d;
         inj_count_q <= inj_count_d;
      end
   end

endmodule
